// File: rtl/mmio_pkg.sv
//------------------------------------------------------------------------------
// Module      : mmio_pkg
// Description : Shared I/O page addresses, stop-FSM states and address decode.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mmio_pkg;

    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } stop_state_t;

    function automatic logic is_io(input logic [17:0] addr);
        return addr[17:16] == 2'b11;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count; head is combinational.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] ptr);
        return (ptr == c_PW'(DEPTH - 1)) ? '0 : ptr + c_PW'(1);
    endfunction

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == c_CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/mmio_bridge.sv
//------------------------------------------------------------------------------
// Module      : mmio_bridge
// Description : CPU byte-bus decoder for RAM and the UART/counter/stop I/O page.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        halted
);

    // One extra physical slot so the stop marker always fits behind user data.
    localparam int c_FIFO_DEPTH = TX_DEPTH + 1;
    localparam int c_CW         = $clog2(c_FIFO_DEPTH + 1);
    localparam logic [c_CW-1:0] c_USER_MAX = c_CW'(TX_DEPTH);
    localparam logic [c_CW-1:0] c_FULL_AT  = c_CW'(TX_DEPTH - FULL_MARGIN);

    stop_state_t     r_state, w_state_next;
    logic [17:0]     w_addr;
    logic            w_io, w_wr, w_rd;
    logic            w_uart_wr, w_stop_wr, w_uart_rd, w_snap_rd;
    logic            w_push, w_pop;
    logic [7:0]      w_push_data, w_head, w_io_byte, w_din;
    logic            w_empty, w_fifo_full;
    logic [c_CW-1:0] w_count, w_count_next;
    logic [31:0]     r_cyc, r_snap;
    logic [7:0]      r_rx_data, r_io_q, r_din_hold;
    logic            r_rx_full, r_sel_io, r_rdy_q, r_buf_full;
    logic            w_unused;

    assign w_addr   = mem_a[17:0];
    assign w_io     = is_io(w_addr);
    assign w_wr     = rdy_in & mem_wr;
    assign w_rd     = rdy_in & ~mem_wr;
    assign w_unused = ^{mem_a[31:18], w_fifo_full};

    assign ram_a    = mem_a[16:0];
    assign ram_dout = mem_dout;
    assign ram_we   = mem_wr & ~w_io & rdy_in;

    assign w_uart_wr = w_wr & (w_addr == IO_UART) & (r_state == RUN);
    assign w_stop_wr = w_wr & (w_addr == IO_CLK) & (r_state == RUN);
    assign w_uart_rd = w_rd & (w_addr == IO_UART);
    assign w_snap_rd = w_rd & (w_addr == IO_CLK);

    assign w_push = (w_uart_wr & (mem_dout != 8'h00) & (w_count < c_USER_MAX))
                  | w_stop_wr;
    assign w_push_data  = w_stop_wr ? 8'h00 : mem_dout;
    assign tx_valid     = ~w_empty & (r_state != HALT);
    assign tx_data      = w_empty ? 8'h00 : w_head;
    assign w_pop        = tx_valid & tx_ready;
    assign w_count_next = w_count + c_CW'(w_push) - c_CW'(w_pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (c_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= RUN;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_stop_wr) w_state_next = DRAIN;
            DRAIN:   if (w_empty)   w_state_next = HALT;
            HALT:    w_state_next = HALT;
            default: w_state_next = RUN;
        endcase
    end

    assign halted = (r_state == HALT);

    always_comb begin
        w_io_byte = 8'h00;
        case (w_addr)
            IO_UART:         w_io_byte = r_rx_full ? r_rx_data : 8'h00;
            IO_CLK:          w_io_byte = r_cyc[7:0];
            IO_CLK + 18'd1:  w_io_byte = r_snap[15:8];
            IO_CLK + 18'd2:  w_io_byte = r_snap[23:16];
            IO_CLK + 18'd3:  w_io_byte = r_snap[31:24];
            default:         w_io_byte = 8'h00;
        endcase
    end

    // After a stalled cycle the bus shows the previously presented byte.
    assign w_din   = r_rdy_q ? (r_sel_io ? r_io_q : ram_din) : r_din_hold;
    assign mem_din = w_din;
    assign io_buffer_full = r_buf_full;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cyc      <= '0;
            r_snap     <= '0;
            r_rx_data  <= '0;
            r_rx_full  <= 1'b0;
            r_sel_io   <= 1'b1;
            r_io_q     <= '0;
            r_rdy_q    <= 1'b0;
            r_din_hold <= '0;
            r_buf_full <= 1'b0;
        end else begin
            if (rdy_in)    r_cyc  <= r_cyc + 32'd1;
            if (w_snap_rd) r_snap <= r_cyc;
            if (rx_valid) begin
                r_rx_data <= rx_data;
                r_rx_full <= 1'b1;
            end else if (w_uart_rd) begin
                r_rx_full <= 1'b0;
            end
            if (w_rd) begin
                r_sel_io <= w_io;
                r_io_q   <= w_io_byte;
            end
            r_rdy_q    <= rdy_in;
            r_din_hold <= w_din;
            r_buf_full <= (w_count_next >= c_FULL_AT);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_bridge.sv
//------------------------------------------------------------------------------
// Module      : tb_mmio_bridge
// Description : Directed vector table plus hand sequences for mmio_bridge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mmio_bridge;

    logic        clk_in   = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in   = 1'b0;
    logic [31:0] mem_a    = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_wr   = 1'b0;
    logic [7:0]  ram_din  = '0;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data  = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        halted;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_cyc;
    logic [31:0] exp_snap;

    typedef struct {
        logic        rdy;
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  dout;
        logic        txr;
        logic        rxv;
        logic [7:0]  rxd;
        logic [7:0]  rdin;
        logic        e_we;
        logic [7:0]  e_din;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_full;
    } vec_t;

    vec_t vecs [12];

    mmio_bridge #(
        .TX_DEPTH    (16),
        .FULL_MARGIN (2)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_dout       (ram_dout),
        .ram_we         (ram_we),
        .ram_din        (ram_din),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .halted         (halted)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle counter: counts every rdy-high edge since reset.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   model_cyc <= '0;
        else if (rdy_in) model_cyc <= model_cyc + 32'd1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
        rdy_in   = 1'b1;
        mem_a    = addr;
        mem_wr   = 1'b1;
        mem_dout = data;
        step();
    endtask

    task automatic bus_idle();
        rdy_in   = 1'b1;
        mem_a    = 32'h0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " mem_din"},        {24'h0, mem_din}, 32'h0);
        chk({tag, " tx_valid"},       {31'h0, tx_valid}, 32'h0);
        chk({tag, " tx_data"},        {24'h0, tx_data}, 32'h0);
        chk({tag, " io_buffer_full"}, {31'h0, io_buffer_full}, 32'h0);
        chk({tag, " halted"},         {31'h0, halted}, 32'h0);
    endtask

    initial begin
        logic [7:0] stop_seq [4];

        //           rdy addr           wr dout  txr rxv rxd   rdin   we din   txv txd   full
        vecs[0]  = '{1'b1, 32'h00030000, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
        vecs[1]  = '{1'b1, 32'h00030000, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 32'h00000100, 1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 32'h00000100, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h12, 1'b0, 8'h12, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 32'h00000000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 8'h33, 1'b0, 8'h33, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 32'h00030000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h77, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 32'h00030000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 32'h00000000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h21, 1'b0, 8'h21, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 32'h00000100, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h55, 1'b0, 8'h21, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 32'h00030000, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 8'h66, 1'b0, 8'h21, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 32'h00030000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h66, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 32'h00030000, 1'b1, 8'h43, 1'b0, 1'b0, 8'h00, 8'h66, 1'b0, 8'h00, 1'b1, 8'h43, 1'b0};

        stop_seq[0] = 8'hA1;
        stop_seq[1] = 8'hA2;
        stop_seq[2] = 8'hA3;
        stop_seq[3] = 8'h00;

        // Reset state
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n_in = 1'b1;
        bus_idle();

        // Vector table
        for (int i = 0; i < 12; i++) begin
            rdy_in   = vecs[i].rdy;
            mem_a    = vecs[i].addr;
            mem_wr   = vecs[i].wr;
            mem_dout = vecs[i].dout;
            tx_ready = vecs[i].txr;
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            #1;
            chk($sformatf("v%0d ram_we", i),   {31'h0, ram_we}, {31'h0, vecs[i].e_we});
            chk($sformatf("v%0d ram_a", i),    {15'h0, ram_a}, {15'h0, vecs[i].addr[16:0]});
            chk($sformatf("v%0d ram_dout", i), {24'h0, ram_dout}, {24'h0, vecs[i].dout});
            @(posedge clk_in);
            #1;
            ram_din = vecs[i].rdin;
            #1;
            chk($sformatf("v%0d mem_din", i),  {24'h0, mem_din}, {24'h0, vecs[i].e_din});
            chk($sformatf("v%0d tx_valid", i), {31'h0, tx_valid}, {31'h0, vecs[i].e_txv});
            chk($sformatf("v%0d tx_data", i),  {24'h0, tx_data}, {24'h0, vecs[i].e_txd});
            chk($sformatf("v%0d full", i),     {31'h0, io_buffer_full}, {31'h0, vecs[i].e_full});
            chk($sformatf("v%0d halted", i),   {31'h0, halted}, 32'h0);
        end
        rx_valid = 1'b0;

        // Drain the leftover byte from the last vector
        bus_idle();
        tx_ready = 1'b1;
        step();
        chk("flush tx_valid", {31'h0, tx_valid}, 32'h0);

        // Fill to the near-full threshold and beyond; 17th write dropped
        tx_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            bus_write(32'h00030000, 8'(i));
            if (i == 13) chk("fill13 full", {31'h0, io_buffer_full}, 32'h0);
            if (i == 14) chk("fill14 full", {31'h0, io_buffer_full}, 32'h1);
        end
        bus_idle();
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d tx_valid", i), {31'h0, tx_valid}, 32'h1);
            chk($sformatf("drain%0d tx_data", i),  {24'h0, tx_data}, i);
            step();
        end
        chk("drain end tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("drain end full",     {31'h0, io_buffer_full}, 32'h0);

        // Cycle counter snapshot
        bus_idle();
        repeat (100) step();
        for (int k = 0; k < 4; k++) begin
            rdy_in = 1'b1;
            mem_wr = 1'b0;
            mem_a  = 32'h00030004 + k;
            if (k == 0) exp_snap = model_cyc;
            step();
            chk($sformatf("cyc byte%0d", k), {24'h0, mem_din}, {24'h0, exp_snap[8*k +: 8]});
        end
        chk("cyc at least 100", {31'h0, (exp_snap >= 32'd100)}, 32'h1);

        // Stop sequence
        tx_ready = 1'b0;
        bus_write(32'h00030000, 8'hA1);
        bus_write(32'h00030000, 8'hA2);
        bus_write(32'h00030000, 8'hA3);
        bus_write(32'h00030004, 8'h55);
        chk("stop halted early", {31'h0, halted}, 32'h0);
        bus_write(32'h00030000, 8'h77);
        bus_idle();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stop%0d tx_valid", i), {31'h0, tx_valid}, 32'h1);
            chk($sformatf("stop%0d tx_data", i),  {24'h0, tx_data}, {24'h0, stop_seq[i]});
            step();
        end
        chk("stop empty tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("stop empty halted",   {31'h0, halted}, 32'h0);
        step();
        chk("stop halted", {31'h0, halted}, 32'h1);
        bus_write(32'h00030000, 8'h88);
        chk("halt write tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("halt sticky",         {31'h0, halted}, 32'h1);

        // Asynchronous reset while draining
        bus_idle();
        rst_n_in = 1'b0;
        step();
        rst_n_in = 1'b1;
        step();
        chk("rereset halted", {31'h0, halted}, 32'h0);
        tx_ready = 1'b0;
        for (int i = 0; i < 14; i++) bus_write(32'h00030000, 8'hB0 + 8'(i));
        bus_idle();
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        step();
        rx_valid = 1'b0;
        mem_a    = 32'h00030000;
        step();
        chk("pre-reset mem_din", {24'h0, mem_din}, 32'h5A);
        bus_write(32'h00030004, 8'h00);
        bus_idle();
        chk("pre-reset full",     {31'h0, io_buffer_full}, 32'h1);
        chk("pre-reset tx_valid", {31'h0, tx_valid}, 32'h1);
        #3;
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("async reset");
        step();
        rst_n_in = 1'b1;
        step();
        step();
        chk("post-reset tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("post-reset halted",   {31'h0, halted}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
